mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle control FSM that sequences the MIPS datapath.
- Consumes opcode/funct from the InstDecode block (fed by the instruction register) plus datapath status.
- Drives every mux select, write enable and ALU op, one state per cycle.
- Handles a ready handshake with the unified memory port, flags illegal instructions, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  6  from InstDecode; must be stable from DECODE until the return to FETCH.
- funct  in  6  from InstDecode.
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the request this cycle.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- ir_we  out  1  load the instruction register.
- pc_we  out  1  load the PC.
- pc_src  out  2  0=ALU result, 1=branch-target register, 2={PC[31:28],target,2'b00}, 3=rs.
- tgt_we  out  1  load the branch-target register from the ALU.
- alu_src_a  out  2  0=PC, 1=rs, 2=shamt.
- alu_src_b  out  3  0=rt, 1=const 4, 2=sext(imm), 3=zext(imm), 4=sext(imm)<<2, 5=imm<<16.
- alu_op  out  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=NOR, 6=SLT, 7=SLTU, 8=SLL, 9=SRL, 10=SRA, 11=PASSB.
- reg_we  out  1  register-file write.
- reg_dst  out  2  0=rt, 1=rd, 2=r31.
- wb_sel  out  2  0=ALU-out register, 1=memory data register, 2=PC.
- illegal  out  1  sticky illegal-instruction flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- **Reset**
  - Reset high at an edge: state<=FETCH, illegal<=0, retired<=0.
  - While Reset is high, mem_re/mem_we/ir_we/pc_we/tgt_we/reg_we are forced to 0.
  - Reset has priority over every transition, including mid-instruction and during a pending memory access. The aborted instruction does not retire and writes nothing after Reset.
- **Output timing**
  - Outputs are combinational from the current state plus opcode/funct.
  - Unlisted enables are 0; unlisted selects are 0.
- **Supported instructions**
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR.
  - I-type: ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
  - Any other opcode, or any other funct with opcode 0, is illegal.
- **States and transitions**
  - FETCH: mem_re=1, alu_src_a=0, alu_src_b=1, alu_op=ADD. Holds until mem_ready. In the mem_ready cycle: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=4, alu_op=ADD, tgt_we=1. Dispatch by instruction class:
    - R-ALU -> EXEC_R.
    - I-ALU -> EXEC_I.
    - LW/SW -> MEM_ADDR.
    - BEQ/BNE -> BRANCH.
    - J/JAL -> JUMP.
    - JR -> JUMP_R.
    - illegal -> HALT.
  - EXEC_R: alu_src_a=1 (2 for shifts), alu_src_b=0, alu_op from funct. Next state WB_ALU.
  - EXEC_I: alu_src_a=1. Immediate selection:
    - alu_src_b=2 for ADDIU/SLTI/SLTIU.
    - alu_src_b=3 for ANDI/ORI/XORI.
    - LUI uses alu_src_b=5 with PASSB.
    - Next state WB_ALU.
  - WB_ALU: reg_we=1, reg_dst=1 for R-type and 0 for I-type, wb_sel=0. Retire, then FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Next state MEM_RD for LW, MEM_WR for SW.
  - MEM_RD: mem_re=1; hold until mem_ready, then WB_MEM.
  - WB_MEM: reg_we=1, reg_dst=0, wb_sel=1. Retire, then FETCH.
  - MEM_WR: mem_we=1; hold until mem_ready. Retire in the mem_ready cycle, then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, SUB. Taken = alu_zero for BEQ, !alu_zero for BNE. If taken: pc_we=1, pc_src=1. Retire, then FETCH.
  - JUMP: pc_we=1, pc_src=2. For JAL also reg_we=1, reg_dst=2, wb_sel=2; the PC already holds PC+4. Retire, then FETCH.
  - JUMP_R: pc_we=1, pc_src=3. Retire, then FETCH.
  - HALT: illegal=1. All enables stay 0 and the state persists until Reset.
- **Latencies** (each memory-wait state adds one cycle per cycle mem_ready is low)
  - R/I ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch, J, JAL, JR: 3 cycles.
- **Retire counter**
  - retired increments by 1 on each retire cycle; it wraps at 2^CNT_W to 0.
  - HALT never retires.
- **Memory handshake**
  - mem_re/mem_we stay asserted and request inputs stay stable until mem_ready.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- **State encoding**
  - 4-bit; unused encodings go to HALT.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 and ADDU (op 0, funct 0x21) → enables 0 during reset. Next cycles: FETCH (mem_re=1, ir_we=1, pc_we=1), DECODE (tgt_we=1), EXEC_R (alu_op=0), WB_ALU (reg_we=1, reg_dst=1). retired=1.
- LW (op 0x23) with mem_ready low 2 cycles in MEM_RD → mem_re held 3 cycles in MEM_RD. WB_MEM has reg_we=1, wb_sel=1. Total 7 cycles, retired+1.
- BEQ (op 0x04): alu_zero=1 → pc_we=1, pc_src=1 in BRANCH. alu_zero=0 → pc_we=0. BNE inverts. Each takes 3 cycles.
- JAL (op 0x03) → JUMP cycle: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wb_sel=2. JR (op 0, funct 0x08) → pc_src=3.
- Opcode 0x3F → DECODE then HALT. illegal=1, retired unchanged, no enables for 10 cycles. Reset clears illegal to 0.
- Reset asserted in MEM_WR while mem_ready=0 → next cycle mem_we=0 and state is FETCH, retired=0. With CNT_W=4, 16 retires wrap retired to 0.

Source files
------------

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// The master modport is the controller side; the slave modport is the datapath side.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             mem_ready;
    logic             mem_re;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             tgt_we;
    logic [1:0]       alu_src_a;
    logic [2:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output mem_re, mem_we, ir_we, pc_we, pc_src, tgt_we, alu_src_a, alu_src_b,
               alu_op, reg_we, reg_dst, wb_sel, illegal, retired
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  mem_re, mem_we, ir_we, pc_we, pc_src, tgt_we, alu_src_a, alu_src_b,
               alu_op, reg_we, reg_dst, wb_sel, illegal, retired
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: one state per cycle, memory ready handshake,
// sticky illegal-instruction flag and a wrapping retired-instruction counter.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mc_control_if.master ctl
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR, S_MEM_RD,
        S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JUMP_R, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        C_R_ALU, C_I_ALU, C_MEM, C_BRANCH, C_JUMP, C_JR, C_ILL
    } iclass_e;

    state_e           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    iclass_e          iclass;
    alu_op_e          r_op, i_op;
    logic [2:0]       i_src_b;
    logic             is_shift;
    logic             retire;
    logic             mem_re_c, mem_we_c, ir_we_c, pc_we_c, tgt_we_c, reg_we_c;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        iclass   = C_ILL;
        r_op     = ALU_ADD;
        i_op     = ALU_ADD;
        i_src_b  = 3'd2;
        is_shift = 1'b0;
        unique case (ctl.opcode)
            6'h00: begin
                iclass = C_R_ALU;
                case (ctl.funct)
                    6'h21:   r_op = ALU_ADD;
                    6'h23:   r_op = ALU_SUB;
                    6'h24:   r_op = ALU_AND;
                    6'h25:   r_op = ALU_OR;
                    6'h26:   r_op = ALU_XOR;
                    6'h27:   r_op = ALU_NOR;
                    6'h2A:   r_op = ALU_SLT;
                    6'h2B:   r_op = ALU_SLTU;
                    6'h00:   begin r_op = ALU_SLL; is_shift = 1'b1; end
                    6'h02:   begin r_op = ALU_SRL; is_shift = 1'b1; end
                    6'h03:   begin r_op = ALU_SRA; is_shift = 1'b1; end
                    6'h08:   iclass = C_JR;
                    default: iclass = C_ILL;
                endcase
            end
            6'h09:   begin iclass = C_I_ALU; i_op = ALU_ADD;  end
            6'h0A:   begin iclass = C_I_ALU; i_op = ALU_SLT;  end
            6'h0B:   begin iclass = C_I_ALU; i_op = ALU_SLTU; end
            6'h0C:   begin iclass = C_I_ALU; i_op = ALU_AND;   i_src_b = 3'd3; end
            6'h0D:   begin iclass = C_I_ALU; i_op = ALU_OR;    i_src_b = 3'd3; end
            6'h0E:   begin iclass = C_I_ALU; i_op = ALU_XOR;   i_src_b = 3'd3; end
            6'h0F:   begin iclass = C_I_ALU; i_op = ALU_PASSB; i_src_b = 3'd5; end
            6'h23, 6'h2B: iclass = C_MEM;
            6'h04, 6'h05: iclass = C_BRANCH;
            6'h02, 6'h03: iclass = C_JUMP;
            default: iclass = C_ILL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH:  if (ctl.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (iclass)
                    C_R_ALU:  state_d = S_EXEC_R;
                    C_I_ALU:  state_d = S_EXEC_I;
                    C_MEM:    state_d = S_MEM_ADDR;
                    C_BRANCH: state_d = S_BRANCH;
                    C_JUMP:   state_d = S_JUMP;
                    C_JR:     state_d = S_JUMP_R;
                    default:  state_d = S_HALT;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (ctl.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (ctl.mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: begin
                if (ctl.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JUMP_R: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        mem_re_c = 1'b0; mem_we_c = 1'b0; ir_we_c = 1'b0;
        pc_we_c  = 1'b0; tgt_we_c = 1'b0; reg_we_c = 1'b0;
        ctl.pc_src    = 2'd0;
        ctl.alu_src_a = 2'd0;
        ctl.alu_src_b = 3'd0;
        ctl.alu_op    = ALU_ADD;
        ctl.reg_dst   = 2'd0;
        ctl.wb_sel    = 2'd0;
        unique case (state_q)
            S_FETCH: begin
                mem_re_c      = 1'b1;
                ctl.alu_src_b = 3'd1;
                ir_we_c       = ctl.mem_ready;
                pc_we_c       = ctl.mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = 3'd4;
                tgt_we_c      = 1'b1;
            end
            S_EXEC_R: begin
                ctl.alu_src_a = is_shift ? 2'd2 : 2'd1;
                ctl.alu_op    = r_op;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 2'd1;
                ctl.alu_src_b = i_src_b;
                ctl.alu_op    = i_op;
            end
            S_WB_ALU: begin
                reg_we_c    = 1'b1;
                ctl.reg_dst = (ctl.opcode == 6'h00) ? 2'd1 : 2'd0;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 2'd1;
                ctl.alu_src_b = 3'd2;
            end
            S_MEM_RD: mem_re_c = 1'b1;
            S_WB_MEM: begin
                reg_we_c   = 1'b1;
                ctl.wb_sel = 2'd1;
            end
            S_MEM_WR: mem_we_c = 1'b1;
            S_BRANCH: begin
                ctl.alu_src_a = 2'd1;
                ctl.alu_op    = ALU_SUB;
                // opcode bit 0 distinguishes BNE (0x05) from BEQ (0x04)
                pc_we_c       = ctl.alu_zero ^ ctl.opcode[0];
                ctl.pc_src    = 2'd1;
            end
            S_JUMP: begin
                pc_we_c    = 1'b1;
                ctl.pc_src = 2'd2;
                if (ctl.opcode == 6'h03) begin
                    reg_we_c    = 1'b1;
                    ctl.reg_dst = 2'd2;
                    ctl.wb_sel  = 2'd2;
                end
            end
            S_JUMP_R: begin
                pc_we_c    = 1'b1;
                ctl.pc_src = 2'd3;
            end
            default: ;
        endcase
    end

    assign ctl.mem_re  = mem_re_c & ~rst_i;
    assign ctl.mem_we  = mem_we_c & ~rst_i;
    assign ctl.ir_we   = ir_we_c  & ~rst_i;
    assign ctl.pc_we   = pc_we_c  & ~rst_i;
    assign ctl.tgt_we  = tgt_we_c & ~rst_i;
    assign ctl.reg_we  = reg_we_c & ~rst_i;
    assign ctl.illegal = illegal_q;
    assign ctl.retired = retired_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_HALT);
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control (CNT_W=4 so the counter wrap is reachable).
module tb_mc_control;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mc_control_if #(.CNT_W(4)) bus ();

    mc_control #(.CNT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctl   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Enable vector order: {mem_re, mem_we, ir_we, pc_we, tgt_we, reg_we}
    function automatic logic [5:0] en();
        return {bus.mem_re, bus.mem_we, bus.ir_we, bus.pc_we, bus.tgt_we, bus.reg_we};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = 1'b1;
        #1;
        check({tag, "_fetch_en"}, en(), 6'b101100);
        check({tag, "_fetch_srcb"}, bus.alu_src_b, 1);
        cyc();
        check({tag, "_decode_en"}, en(), 6'b000010);
        check({tag, "_decode_srcb"}, bus.alu_src_b, 4);
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 6'h00; bus.funct = 6'h21; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
        #1;
        check("rst_en_t0", en(), 0);
        repeat (3) begin
            cyc();
            check("rst_en", en(), 0);
        end
        check("rst_retired", bus.retired, 0);
        check("rst_illegal", bus.illegal, 0);
        rst = 1'b0;

        // ADDU
        fetch_decode("addu", 6'h00, 6'h21);
        check("addu_exec_en", en(), 0);
        check("addu_exec_op", bus.alu_op, 0);
        check("addu_exec_srca", bus.alu_src_a, 1);
        check("addu_exec_srcb", bus.alu_src_b, 0);
        cyc();
        check("addu_wb_en", en(), 6'b000001);
        check("addu_wb_dst", bus.reg_dst, 1);
        check("addu_wb_sel", bus.wb_sel, 0);
        cyc();
        check("addu_retired", bus.retired, 1);

        // LW with two wait cycles in MEM_RD
        fetch_decode("lw", 6'h23, 6'h00);
        bus.mem_ready = 1'b0;
        #1;
        check("lw_addr_en", en(), 0);
        check("lw_addr_srca", bus.alu_src_a, 1);
        check("lw_addr_srcb", bus.alu_src_b, 2);
        cyc();
        check("lw_rd1", en(), 6'b100000);
        cyc();
        check("lw_rd2", en(), 6'b100000);
        bus.mem_ready = 1'b1;
        #1;
        check("lw_rd3", en(), 6'b100000);
        cyc();
        check("lw_wb_en", en(), 6'b000001);
        check("lw_wb_sel", bus.wb_sel, 1);
        check("lw_wb_dst", bus.reg_dst, 0);
        cyc();
        check("lw_retired", bus.retired, 2);

        // Branches: {opcode, alu_zero} -> taken
        fetch_decode("beq_t", 6'h04, 6'h00);
        bus.alu_zero = 1'b1; #1;
        check("beq_t_en", en(), 6'b000100);
        check("beq_t_pcsrc", bus.pc_src, 1);
        check("beq_t_op", bus.alu_op, 1);
        cyc();
        fetch_decode("beq_n", 6'h04, 6'h00);
        bus.alu_zero = 1'b0; #1;
        check("beq_n_en", en(), 0);
        cyc();
        fetch_decode("bne_n", 6'h05, 6'h00);
        bus.alu_zero = 1'b1; #1;
        check("bne_n_en", en(), 0);
        cyc();
        fetch_decode("bne_t", 6'h05, 6'h00);
        bus.alu_zero = 1'b0; #1;
        check("bne_t_en", en(), 6'b000100);
        cyc();
        check("branch_retired", bus.retired, 6);

        // JAL and JR
        fetch_decode("jal", 6'h03, 6'h00);
        check("jal_en", en(), 6'b000101);
        check("jal_pcsrc", bus.pc_src, 2);
        check("jal_dst", bus.reg_dst, 2);
        check("jal_wbsel", bus.wb_sel, 2);
        cyc();
        fetch_decode("jr", 6'h00, 6'h08);
        check("jr_en", en(), 6'b000100);
        check("jr_pcsrc", bus.pc_src, 3);
        cyc();
        check("jump_retired", bus.retired, 8);

        // ORI (zero-extended immediate, rt destination) and SLL (shamt source)
        fetch_decode("ori", 6'h0D, 6'h00);
        check("ori_srcb", bus.alu_src_b, 3);
        check("ori_op", bus.alu_op, 3);
        cyc();
        check("ori_wb_dst", bus.reg_dst, 0);
        cyc();
        fetch_decode("sll", 6'h00, 6'h00);
        check("sll_srca", bus.alu_src_a, 2);
        check("sll_op", bus.alu_op, 8);
        cyc();
        cyc();

        // SW with ready immediately: 4 cycles
        fetch_decode("sw", 6'h2B, 6'h00);
        cyc();
        check("sw_wr_en", en(), 6'b010000);
        cyc();
        check("sw_retired", bus.retired, 11);

        // Illegal opcode halts until reset
        fetch_decode("ill", 6'h3F, 6'h00);
        for (int i = 0; i < 10; i++) begin
            check("halt_en", en(), 0);
            check("halt_illegal", bus.illegal, 1);
            cyc();
        end
        check("halt_retired", bus.retired, 11);
        rst = 1'b1; #1;
        check("halt_rst_en", en(), 0);
        cyc();
        rst = 1'b0;
        check("halt_rst_illegal", bus.illegal, 0);
        check("halt_rst_retired", bus.retired, 0);

        // Reset during a pending store
        fetch_decode("swr", 6'h2B, 6'h00);
        bus.mem_ready = 1'b0;
        cyc();
        check("swr_wr_en", en(), 6'b010000);
        rst = 1'b1; #1;
        check("swr_rst_en", en(), 0);
        cyc();
        rst = 1'b0; #1;
        check("swr_fetch_en", en(), 6'b100000);
        check("swr_retired", bus.retired, 0);

        // 16 retires wrap a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            fetch_decode("wrap_jr", 6'h00, 6'h08);
            cyc();
            if (i == 14) check("wrap_15", bus.retired, 15);
        end
        check("wrap_0", bus.retired, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
